// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the sequential ALU.
//   op_e    - 4-bit operation codes (13..15 reserved)
//   state_e - top-level handshake FSM states
//   flags_t - registered result flags
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_NOT  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SEQ  = 4'd7,
        OP_SLTU = 4'd8,
        OP_SLL  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11,
        OP_MUL  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic overflow;
    } flags_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: iterative datapath for bit-serial shifts and shift-add multiply.
//   clk, rst_n - clock, synchronous active-low reset
//   start_i    - load operands and begin (op_i must be SLL/SRL/SRA/MUL, shamt > 0 for shifts)
//   op_i       - operation code
//   a_i, b_i   - operands; b_i low bits are the shift amount for shifts
//   done_o     - high during the final step; res_o/carry_o are valid in that cycle
//   res_o      - result after the current step
//   carry_o    - last bit shifted out, or high-half-nonzero for MUL
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o
);
    localparam int unsigned SHW = $clog2(WIDTH);
    // One extra bit so the counter can hold WIDTH for multiply.
    localparam int unsigned CW  = SHW + 1;

    logic               busy_q, busy_d;
    logic [3:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               carry_q, carry_d;
    logic [2*WIDTH-1:0] mc_q, mc_d;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]   mr_q, mr_d;    // multiplier, consumed LSB first
    logic [2*WIDTH-1:0] acc_q, acc_d;  // full-width product accumulator

    always_comb begin
        busy_d  = busy_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        mc_d    = mc_q;
        mr_d    = mr_q;
        acc_d   = acc_q;
        if (start_i) begin
            busy_d  = 1'b1;
            op_d    = op_i;
            sh_d    = a_i;
            carry_d = 1'b0;
            mc_d    = {{WIDTH{1'b0}}, a_i};
            mr_d    = b_i;
            acc_d   = '0;
            if (op_i == OP_MUL) cnt_d = CW'(WIDTH);
            else                cnt_d = {1'b0, b_i[SHW-1:0]};
        end else if (busy_q) begin
            case (op_e'(op_q))
                OP_SLL: begin
                    carry_d = sh_q[WIDTH-1];
                    sh_d    = {sh_q[WIDTH-2:0], 1'b0};
                end
                OP_SRL: begin
                    carry_d = sh_q[0];
                    sh_d    = {1'b0, sh_q[WIDTH-1:1]};
                end
                OP_SRA: begin
                    carry_d = sh_q[0];
                    sh_d    = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                end
                OP_MUL: begin
                    if (mr_q[0]) acc_d = acc_q + mc_q;
                    mc_d = {mc_q[2*WIDTH-2:0], 1'b0};
                    mr_d = {1'b0, mr_q[WIDTH-1:1]};
                end
                default: ;
            endcase
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    // Results are taken from the next-state values so the top can capture them
    // on the same edge that performs the final step.
    assign done_o  = busy_q && (cnt_q == CW'(1));
    assign res_o   = (op_q == OP_MUL) ? acc_d[WIDTH-1:0] : sh_d;
    assign carry_o = (op_q == OP_MUL) ? (|acc_d[2*WIDTH-1:WIDTH]) : carry_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            op_q    <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            mc_q    <= '0;
            mr_q    <= '0;
            acc_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            mc_q    <= mc_d;
            mr_q    <= mr_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake on operand and result sides.
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - operand beat handshake; in_ready only in IDLE
//   in_op, in_a, in_b     - opcode and operands (in_b low bits = shift amount)
//   out_valid/out_ready   - result handshake; result held until accepted
//   out_res               - registered result
//   out_zero/out_neg/out_carry/out_overflow - registered flags
// Build option: define SEQ_ALU_FAST_SHIFT_EN for single-cycle barrel shifts.
// Multiply is always iterative via seq_alu_iter.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_overflow
);
    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    flags_t           flags_q, flags_d;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic             sc_iter;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic [WIDTH:0]   add_full;

    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_carry;

    assign shamt  = in_b[SHW-1:0];
    assign accept = in_valid && (state_q == ST_IDLE);

    // Single-cycle result for the current operand beat; sc_iter flags ops that
    // must go through the iterative datapath instead.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_iter  = 1'b0;
        add_full = '0;
        case (op_e'(in_op))
            OP_ADD: begin
                add_full = {1'b0, in_a} + {1'b0, in_b};
                sc_res   = add_full[WIDTH-1:0];
                sc_carry = add_full[WIDTH];
                sc_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                           (sc_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                add_full = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
                sc_res   = add_full[WIDTH-1:0];
                sc_carry = add_full[WIDTH];
                sc_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                           (sc_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_NOT:  sc_res = ~in_a;
            OP_AND:  sc_res = in_a & in_b;
            OP_OR:   sc_res = in_a | in_b;
            OP_XOR:  sc_res = in_a ^ in_b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SEQ:  sc_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_SLL, OP_SRL, OP_SRA: begin
                if (shamt == '0) begin
                    sc_res = in_a;
                end else begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
                    // Extra guard bit on the shifted-out side captures the
                    // last bit lost, matching the iterative carry.
                    logic [WIDTH:0] sh_l;
                    logic [WIDTH:0] sh_r;
                    logic [WIDTH:0] sh_a;
                    sh_l = {1'b0, in_a} << shamt;
                    sh_r = {in_a, 1'b0} >> shamt;
                    sh_a = $signed({in_a, 1'b0}) >>> shamt;
                    if (in_op == OP_SLL)      {sc_carry, sc_res} = sh_l;
                    else if (in_op == OP_SRL) {sc_res, sc_carry} = sh_r;
                    else                      {sc_res, sc_carry} = sh_a;
`else
                    sc_iter = 1'b1;
`endif
                end
            end
            OP_MUL:  sc_iter = 1'b1;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        flags_d    = flags_q;
        iter_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sc_iter) begin
                        iter_start = 1'b1;
                        state_d    = ST_BUSY;
                    end else begin
                        res_d            = sc_res;
                        flags_d.zero     = (sc_res == '0);
                        flags_d.neg      = sc_res[WIDTH-1];
                        flags_d.carry    = sc_carry;
                        flags_d.overflow = sc_ovf;
                        state_d          = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    res_d            = iter_res;
                    flags_d.zero     = (iter_res == '0);
                    flags_d.neg      = iter_res[WIDTH-1];
                    flags_d.carry    = iter_carry;
                    flags_d.overflow = 1'b0;
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    seq_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (iter_start),
        .op_i    (in_op),
        .a_i     (in_a),
        .b_i     (in_b),
        .done_o  (iter_done),
        .res_o   (iter_res),
        .carry_o (iter_carry)
    );

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign out_res      = res_q;
    assign out_zero     = flags_q.zero;
    assign out_neg      = flags_q.neg;
    assign out_carry    = flags_q.carry;
    assign out_overflow = flags_q.overflow;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_op = 4'd0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_res;
    logic       out_zero;
    logic       out_neg;
    logic       out_carry;
    logic       out_overflow;

    int checks = 0;
    int errors = 0;

    seq_alu #(
        .WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_zero     (out_zero),
        .out_neg      (out_neg),
        .out_carry    (out_carry),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    // Reference model from the arithmetic definitions.
    // f = {zero, neg, carry, overflow}; cyc = cycles from accept to out_valid.
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic [3:0] f, output int cyc);
        int sa, sb, s, n;
        logic c, v;
        logic [31:0] t;
        sa = $signed(a);
        sb = $signed(b);
        n  = int'(b[2:0]);
        c = 1'b0; v = 1'b0; r = 8'd0; cyc = 1;
        case (op)
            4'd0: begin
                r = a + b; c = (int'(a) + int'(b)) > 255;
                s = sa + sb; v = (s > 127) || (s < -128);
            end
            4'd1: begin
                r = a - b; c = (a >= b);
                s = sa - sb; v = (s > 127) || (s < -128);
            end
            4'd2: r = ~a;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = (sa < sb) ? 8'd1 : 8'd0;
            4'd7: r = (a == b) ? 8'd1 : 8'd0;
            4'd8: r = (a < b) ? 8'd1 : 8'd0;
            4'd9: begin
                t = 32'(a) << n; r = t[7:0]; c = (n > 0) ? t[8] : 1'b0;
            end
            4'd10: begin
                r = a >> n; c = (n > 0) ? a[n-1] : 1'b0;
            end
            4'd11: begin
                t = sa >>> n; r = t[7:0]; c = (n > 0) ? a[n-1] : 1'b0;
            end
            4'd12: begin
                t = 32'(a) * 32'(b); r = t[7:0]; c = (t > 32'd255); cyc = 9;
            end
            default: r = 8'd0;
        endcase
`ifndef SEQ_ALU_FAST_SHIFT_EN
        if (op >= 4'd9 && op <= 4'd11) cyc = 1 + n;
`endif
        f = {(r == 8'd0), r[7], c, v};
    endtask

    // Issue one op, check latency, result, hold under backpressure and release.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input logic [7:0] er, input logic [3:0] ef,
                          input int ecyc, input string name);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b expected 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        // Garbage on the inputs while busy must be ignored.
        in_valid = 1'($urandom); in_op = 4'($urandom); in_a = 8'($urandom);
        in_b = 8'($urandom);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) break;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_while_busy got %b expected 0", name, in_ready);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (cyc != ecyc || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency got %0d (valid=%b) expected %0d", name, cyc, out_valid,
                     ecyc);
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({out_res, out_zero, out_neg, out_carry, out_overflow, out_valid, in_ready}
                !== {er, ef, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s result[%0d] got res=%h znco=%b v=%b r=%b expected res=%h znco=%b v=1 r=0",
                         name, i, out_res, {out_zero, out_neg, out_carry, out_overflow},
                         out_valid, in_ready, er, ef);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release got ready=%b valid=%b expected ready=1 valid=0", name,
                     in_ready, out_valid);
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if ({out_valid, out_res, out_zero, out_neg, out_carry, out_overflow} !== 13'd0) begin
            errors++;
            $display("FAIL %s cleared got valid=%b res=%h znco=%b expected all 0", name,
                     out_valid, out_res, {out_zero, out_neg, out_carry, out_overflow});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int sra_cyc;
`ifdef SEQ_ALU_FAST_SHIFT_EN
        sra_cyc = 1;
`else
        sra_cyc = 4;
`endif
        run_op(4'd0,  8'h7F, 8'h01, 0, 8'h80, 4'b0101, 1, "add_7f_01");
        run_op(4'd1,  8'h05, 8'h05, 0, 8'h00, 4'b1010, 1, "sub_eq");
        run_op(4'd1,  8'h00, 8'h01, 0, 8'hFF, 4'b0100, 1, "sub_borrow");
        run_op(4'd11, 8'h90, 8'h03, 0, 8'hF2, 4'b0100, sra_cyc, "sra_90_3");
        run_op(4'd12, 8'd15, 8'd17, 0, 8'hFF, 4'b0100, 9, "mul_15_17");
        run_op(4'd12, 8'd16, 8'd16, 0, 8'h00, 4'b1010, 9, "mul_16_16");
        run_op(4'd6,  8'h80, 8'h01, 0, 8'h01, 4'b0000, 1, "slt_neg");
        run_op(4'd10, 8'hA5, 8'h08, 0, 8'hA5, 4'b0100, 1, "srl_zero_shamt");
        run_op(4'd13, 8'hFF, 8'hFF, 0, 8'h00, 4'b1000, 1, "reserved13");
    endtask

    task automatic test_backpressure();
        run_op(4'd0, 8'h12, 8'h34, 5, 8'h46, 4'b0000, 1, "bp_add");
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [7:0] a, b, er;
        logic [3:0] ef;
        int ecyc;
        for (int k = 0; k < 150; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            model(op, a, b, er, ef, ecyc);
            run_op(op, a, b, int'($urandom_range(0, 3)), er, ef, ecyc,
                   $sformatf("rand%0d_op%0d", k, op));
        end
    endtask

    task automatic test_reset_mid_op();
        int bad;
        // Reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd12; in_a = 8'd15; in_b = 8'd17;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("reset_mid_mul");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul_ready got %b expected 1", in_ready);
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || out_res !== 8'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_mul_stale got %0d bad cycles expected 0", bad);
        end
        // Reset while a result is held under backpressure.
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd5; in_a = 8'hF0; in_b = 8'h0F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_res !== 8'hFF) begin
            errors++;
            $display("FAIL reset_done_pre got valid=%b res=%h expected valid=1 res=ff",
                     out_valid, out_res);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("reset_in_done");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd3, 8'hCC, 8'hAA, 1, 8'h88, 4'b0100, 1, "after_reset_and");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
